regfile_sb: RTL and testbench

Parametrised successor to the MIPS32 register file, used by the decode/writeback stages of the pipelined core. It provides NRD asynchronous read ports, one synchronous write port, synchronous reset, and R0 hardwired to zero. A per-register scoreboard lets decode claim a destination at issue; writeback releases it, so hazard logic can stall on pending writes.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 58 +++++
 rtl/regfile_sb.sv | 85 ++++++++
 tb/tb_regfile_sb.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DEF_DW   = 32;
  localparam int unsigned DEF_NREG = 32;
  localparam int unsigned ZERO_REG = 0;
  localparam int unsigned CNT_W    = 8;

  function automatic logic [CNT_W-1:0] popcount_next(input logic [CNT_W-1:0] busy_cnt,
                                                     input logic             set,
                                                     input logic             clr);
    case ({set, clr})
      2'b10:   return busy_cnt + CNT_W'(1);
      2'b01:   return busy_cnt - CNT_W'(1);
      default: return busy_cnt;
    endcase
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: decode claims a destination, writeback releases it.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = DEF_NREG,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic            claim_en,
  input  logic [AW-1:0]   claim_addr,
  output logic            claim_rdy,
  output logic [NREG-1:0] busy,
  output logic [AW:0]     busy_cnt
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            set, clr;

  always_comb begin
    busy_d    = busy_q;
    set       = 1'b0;
    clr       = 1'b0;
    claim_rdy = (claim_addr == AW'(ZERO_REG));
    for (int unsigned r = 1; r < NREG; r++) begin
      if (claim_addr == AW'(r)) claim_rdy = !busy_q[r];
      if (wr_en && (wr_addr == AW'(r)) && busy_q[r]) begin
        busy_d[r] = 1'b0;
        clr       = 1'b1;
      end
    end
    // A claim only lands on a non-busy register, so it never races its own clear.
    for (int unsigned r = 1; r < NREG; r++) begin
      if (claim_en && (claim_addr == AW'(r)) && !busy_q[r]) begin
        busy_d[r] = 1'b1;
        set       = 1'b1;
      end
    end
    cnt_d = (AW+1)'(popcount_next(CNT_W'(cnt_q), set, clr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with R0 hardwired to zero and a destination scoreboard.
// Define REGFILE_SB_WR_BYPASS_EN to forward same-cycle writeback data onto read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned NREG = DEF_NREG,
  parameter int unsigned AW   = $clog2(NREG),
  parameter int unsigned NRD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              claim_en,
  input  logic [AW-1:0]     claim_addr,
  output logic              claim_rdy,
  output logic [AW:0]       busy_cnt
);

  logic [DW-1:0]   mem_q [NREG];
  logic [NREG-1:0] busy;

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .claim_rdy  (claim_rdy),
    .busy       (busy),
    .busy_cnt   (busy_cnt)
  );

  // Entry 0 is cleared by reset and never written, so it always reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else begin
      for (int unsigned r = ZERO_REG + 1; r < NREG; r++) begin
        if (wr_en && (wr_addr == AW'(r))) mem_q[r] <= wr_data;
      end
    end
  end

`ifdef REGFILE_SB_WR_BYPASS_EN
  logic wr_valid;

  always_comb begin
    wr_valid = 1'b0;
    for (int unsigned r = ZERO_REG + 1; r < NREG; r++) begin
      if (wr_en && (wr_addr == AW'(r))) wr_valid = 1'b1;
    end
  end
`endif

  // Out-of-range addresses match no entry and fall through to zero / not busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      for (int unsigned r = ZERO_REG + 1; r < NREG; r++) begin
        if (rd_addr[i*AW +: AW] == AW'(r)) begin
          rd_data[i*DW +: DW] = mem_q[r];
          rd_busy[i]          = busy[r];
        end
      end
`ifdef REGFILE_SB_WR_BYPASS_EN
      if (wr_valid && (wr_addr == rd_addr[i*AW +: AW])) begin
        rd_data[i*DW +: DW] = wr_data;
        rd_busy[i]          = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic vs a model.
module tb_regfile_sb;

  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 6;
  localparam int unsigned NRD  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              claim_en;
  logic [AW-1:0]     claim_addr;
  logic              claim_rdy;
  logic [AW:0]       busy_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] m_reg  [64];
  bit            m_busy [64];

  always #5 clk = ~clk;

  regfile_sb #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW),
    .NRD  (NRD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .claim_rdy  (claim_rdy),
    .busy_cnt   (busy_cnt)
  );

  // ---------------- reference model ----------------
  function automatic bit valid_addr(int a);
    return (a != 0) && (a < int'(NREG));
  endfunction

  function automatic bit bypass_hit(int a);
`ifdef REGFILE_SB_WR_BYPASS_EN
    return wr_en && valid_addr(a) && (int'(wr_addr) == a);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_data(int a);
    if (!valid_addr(a)) return '0;
    if (bypass_hit(a)) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(int a);
    if (!valid_addr(a) || bypass_hit(a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_rdy(int a);
    if (a == 0) return 1'b1;
    if (a >= int'(NREG)) return 1'b0;
    return !m_busy[a];
  endfunction

  function automatic logic [AW:0] exp_cnt();
    int n = 0;
    for (int i = 0; i < 64; i++) n += int'(m_busy[i]);
    return (AW+1)'(n);
  endfunction

  // Applies one clock edge and advances the model with the inputs held across it.
  task automatic tick();
    bit c_ok;
    int ca;
    int wa;
    @(posedge clk);
    ca = int'(claim_addr);
    wa = int'(wr_addr);
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      c_ok = claim_en && exp_rdy(ca);
      if (wr_en && valid_addr(wa)) begin
        m_reg[wa]  = wr_data;
        m_busy[wa] = 1'b0;
      end
      if (c_ok && ca != 0) m_busy[ca] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    rst      = 1'b0;
    wr_en    = 1'b0;
    claim_en = 1'b0;
  endtask

  task automatic set_rd(int p, int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  function automatic logic [DW-1:0] port(int p);
    return rd_data[p*DW +: DW];
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'hDEAD_BEEF;
    tick();
    idle();
    claim_en = 1'b1; claim_addr = 6'd5;
    tick();
    idle();
    set_rd(0, 5); set_rd(1, 5); set_rd(2, 5);
    #1;
    n_vec++;
    if (port(0) !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL pre_reset_data: got %h want %h", port(0), 32'hDEAD_BEEF);
    end
    n_vec++;
    if (busy_cnt !== 7'd1) begin
      n_err++; $display("FAIL pre_reset_cnt: got %0d want 1", busy_cnt);
    end
    // Reset must win over a concurrent write and claim.
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 6'd6; wr_data = 32'h0BAD_0BAD;
    claim_en = 1'b1; claim_addr = 6'd6;
    tick();
    idle();
    set_rd(2, 6);
    #1;
    n_vec++;
    if (port(0) !== '0) begin
      n_err++; $display("FAIL reset_data_r5: got %h want 0", port(0));
    end
    n_vec++;
    if (port(2) !== '0) begin
      n_err++; $display("FAIL reset_beats_write_r6: got %h want 0", port(2));
    end
    n_vec++;
    if (busy_cnt !== '0) begin
      n_err++; $display("FAIL reset_cnt: got %0d want 0", busy_cnt);
    end
    n_vec++;
    if (rd_busy !== 3'b000) begin
      n_err++; $display("FAIL reset_busy: got %b want 000", rd_busy);
    end
    n_vec++;
    if (claim_rdy !== 1'b1) begin
      n_err++; $display("FAIL reset_claim_rdy: got %b want 1", claim_rdy);
    end
  endtask

  task automatic test_r0_range();
    idle();
    wr_en = 1'b1; wr_addr = 6'd0; wr_data = 32'h1234;
    tick();
    wr_addr = 6'd40;
    tick();
    idle();
    set_rd(0, 0); set_rd(1, 40); set_rd(2, 8);
    claim_addr = 6'd40;
    #1;
    n_vec++;
    if (port(0) !== '0 || port(1) !== '0 || port(2) !== '0) begin
      n_err++; $display("FAIL r0_range_data: got %h/%h/%h want 0/0/0", port(0), port(1), port(2));
    end
    n_vec++;
    if (rd_busy !== 3'b000) begin
      n_err++; $display("FAIL r0_range_busy: got %b want 000", rd_busy);
    end
    n_vec++;
    if (claim_rdy !== 1'b0) begin
      n_err++; $display("FAIL claim_rdy_out_of_range: got %b want 0", claim_rdy);
    end
    claim_addr = 6'd0;
    claim_en   = 1'b1;
    #1;
    n_vec++;
    if (claim_rdy !== 1'b1) begin
      n_err++; $display("FAIL claim_rdy_r0: got %b want 1", claim_rdy);
    end
    tick();
    idle();
    #1;
    n_vec++;
    if (busy_cnt !== '0) begin
      n_err++; $display("FAIL claim_r0_no_effect: got %0d want 0", busy_cnt);
    end
  endtask

  task automatic test_claim_release();
    idle();
    claim_en = 1'b1; claim_addr = 6'd7;
    tick();
    idle();
    set_rd(0, 7);
    #1;
    n_vec++;
    if (rd_busy[0] !== 1'b1 || busy_cnt !== 7'd1) begin
      n_err++; $display("FAIL claim_r7: got busy %b cnt %0d want 1/1", rd_busy[0], busy_cnt);
    end
    n_vec++;
    if (claim_rdy !== 1'b0) begin
      n_err++; $display("FAIL reclaim_rdy: got %b want 0", claim_rdy);
    end
    claim_en = 1'b1;
    tick();
    idle();
    #1;
    n_vec++;
    if (busy_cnt !== 7'd1) begin
      n_err++; $display("FAIL reclaim_cnt: got %0d want 1", busy_cnt);
    end
    wr_en = 1'b1; wr_addr = 6'd7; wr_data = 32'hA5A5_A5A5;
    tick();
    idle();
    #1;
    n_vec++;
    if (rd_busy[0] !== 1'b0 || busy_cnt !== '0 || port(0) !== 32'hA5A5_A5A5) begin
      n_err++; $display("FAIL release_r7: got busy %b cnt %0d data %h want 0/0/a5a5a5a5",
                        rd_busy[0], busy_cnt, port(0));
    end
  endtask

  task automatic test_simultaneous();
    idle();
    claim_en = 1'b1; claim_addr = 6'd9;
    tick();
    idle();
    claim_en = 1'b1; claim_addr = 6'd3;
    wr_en = 1'b1; wr_addr = 6'd9; wr_data = 32'h99;
    tick();
    idle();
    set_rd(0, 3); set_rd(1, 9);
    #1;
    n_vec++;
    if (busy_cnt !== 7'd1 || rd_busy[1:0] !== 2'b01 || port(1) !== 32'h99) begin
      n_err++; $display("FAIL claim3_write9: got cnt %0d busy %b r9 %h want 1/01/99",
                        busy_cnt, rd_busy[1:0], port(1));
    end
    claim_en = 1'b1; claim_addr = 6'd4;
    wr_en = 1'b1; wr_addr = 6'd4; wr_data = 32'h44;
    #1;
    n_vec++;
    if (claim_rdy !== 1'b1) begin
      n_err++; $display("FAIL claim4_rdy: got %b want 1", claim_rdy);
    end
    tick();
    idle();
    set_rd(2, 4);
    #1;
    n_vec++;
    if (rd_busy[2] !== 1'b1 || port(2) !== 32'h44 || busy_cnt !== 7'd2) begin
      n_err++; $display("FAIL claim4_write4: got busy %b data %h cnt %0d want 1/44/2",
                        rd_busy[2], port(2), busy_cnt);
    end
    // R3 busy: the claim is refused and the write releases it.
    claim_en = 1'b1; claim_addr = 6'd3;
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 32'h33;
    #1;
    n_vec++;
    if (claim_rdy !== 1'b0) begin
      n_err++; $display("FAIL claim3_busy_rdy: got %b want 0", claim_rdy);
    end
    tick();
    idle();
    #1;
    n_vec++;
    if (rd_busy[0] !== 1'b0 || busy_cnt !== 7'd1 || port(0) !== 32'h33) begin
      n_err++; $display("FAIL claim3_write3: got busy %b cnt %0d data %h want 0/1/33",
                        rd_busy[0], busy_cnt, port(0));
    end
  endtask

  task automatic test_multiport();
    idle();
    wr_en = 1'b1; wr_addr = 6'd1; wr_data = 32'h1111_0001;
    tick();
    wr_addr = 6'd2; wr_data = 32'h2222_0002;
    tick();
    idle();
    set_rd(0, 1); set_rd(1, 2); set_rd(2, 1);
    #1;
    n_vec++;
    if (port(0) !== 32'h1111_0001 || port(1) !== 32'h2222_0002 || port(2) !== 32'h1111_0001) begin
      n_err++; $display("FAIL multiport: got %h/%h/%h want 11110001/22220002/11110001",
                        port(0), port(1), port(2));
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want_d;
    logic          want_b;
`ifdef REGFILE_SB_WR_BYPASS_EN
    want_d = 32'h55;
    want_b = 1'b0;
`else
    want_d = 32'h0;
    want_b = 1'b1;
`endif
    idle();
    claim_en = 1'b1; claim_addr = 6'd10;
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 6'd10; wr_data = 32'h55;
    set_rd(0, 10);
    #1;
    n_vec++;
    if (port(0) !== want_d || rd_busy[0] !== want_b) begin
      n_err++; $display("FAIL bypass_same_cycle: got %h busy %b want %h busy %b",
                        port(0), rd_busy[0], want_d, want_b);
    end
    tick();
    idle();
    #1;
    n_vec++;
    if (port(0) !== 32'h55 || rd_busy[0] !== 1'b0) begin
      n_err++; $display("FAIL bypass_next_cycle: got %h busy %b want 55 busy 0",
                        port(0), rd_busy[0]);
    end
  endtask

  task automatic test_random();
    int a;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst        = ($urandom_range(0, 79) == 0);
      wr_en      = $urandom_range(0, 1) == 1;
      wr_addr    = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 63))
                                               : AW'($urandom_range(0, 15));
      wr_data    = $urandom;
      claim_en   = $urandom_range(0, 1) == 1;
      claim_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 63))
                                               : AW'($urandom_range(0, 15));
      for (int p = 0; p < int'(NRD); p++) begin
        set_rd(p, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))
                                              : int'($urandom_range(0, 15)));
      end
      #1;
      for (int p = 0; p < int'(NRD); p++) begin
        a = int'(rd_addr[p*AW +: AW]);
        n_vec++;
        if (port(p) !== exp_data(a) || rd_busy[p] !== exp_busy(a)) begin
          n_err++; $display("FAIL rand_read cyc %0d port %0d addr %0d: got %h/%b want %h/%b",
                            cyc, p, a, port(p), rd_busy[p], exp_data(a), exp_busy(a));
        end
      end
      n_vec++;
      if (claim_rdy !== exp_rdy(int'(claim_addr)) || busy_cnt !== exp_cnt()) begin
        n_err++; $display("FAIL rand_sb cyc %0d: got rdy %b cnt %0d want rdy %b cnt %0d",
                          cyc, claim_rdy, busy_cnt, exp_rdy(int'(claim_addr)), exp_cnt());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    claim_en   = 1'b0;
    claim_addr = '0;
    rd_addr    = '0;
    for (int i = 0; i < 64; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    #1;
    tick();
    tick();
    test_reset();
    test_r0_range();
    test_claim_release();
    test_simultaneous();
    test_multiport();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
